// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle: instruction-memory request/ack and the decode valid/ready handshake.
// The sequencer uses the master modport; memory and decode models use the slave modport.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              inst_valid;
    logic [31:0]       inst_out;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;

    modport master (
        output imem_req, imem_addr, inst_valid, inst_out, inst_pc,
        input  imem_ack, imem_rdata, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_out, inst_pc,
        output imem_ack, imem_rdata, inst_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// PC sequencer with single-outstanding instruction fetch, decode handshake,
// branch redirect, halt and imem ack-timeout fault.
module fetch_sequencer #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               reset,
    fetch_sequencer_if.master  bus,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    input  logic               halt_i,
    output logic               halted_o,
    output logic               fetch_err_o
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_DROP, S_HOLD, S_HALTED, S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              halt_pend_q, halt_pend_d;
    logic              inst_valid_q, inst_valid_d;
    logic [31:0]       inst_out_q, inst_out_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              fetch_err_q, fetch_err_d;
    logic [ADDR_W-1:0] redirect_tgt;

    // Targets are word aligned; the low two address bits are simply masked off.
    assign redirect_tgt = redirect_pc_i & ~ADDR_W'(3);

    // NOTE: every variable is given its default first, so no path through the case leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        wait_cnt_d   = '0;
        halt_pend_d  = halt_pend_q;
        inst_valid_d = inst_valid_q;
        inst_out_d   = inst_out_q;
        inst_pc_d    = inst_pc_q;
        fetch_err_d  = fetch_err_q;

        case (state_q)
            S_IDLE: begin
                if (redirect_i) begin
                    pc_d    = redirect_tgt;
                    state_d = S_REQ;
                end else if (halt_i) begin
                    state_d = S_HALTED;
                end else begin
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                if (redirect_i) begin
                    // Any ack this cycle belongs to the squashed fetch and is discarded.
                    pc_d    = redirect_tgt;
                    state_d = S_DROP;
                end else begin
                    if (halt_i) halt_pend_d = 1'b1;
                    if (bus.imem_ack) begin
                        inst_out_d   = bus.imem_rdata;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        pc_d         = pc_q + ADDR_W'(4);
                        state_d      = S_HOLD;
                    end else if (wait_cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                        fetch_err_d = 1'b1;
                        state_d     = S_ERROR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end
            end

            S_DROP: begin
                if (redirect_i)  pc_d        = redirect_tgt;
                else if (halt_i) halt_pend_d = 1'b1;
                state_d = S_REQ;
            end

            S_HOLD: begin
                if (redirect_i) begin
                    inst_valid_d = 1'b0;
                    pc_d         = redirect_tgt;
                    state_d      = S_REQ;
                end else if (bus.inst_ready) begin
                    inst_valid_d = 1'b0;
                    if (halt_pend_q || halt_i) begin
                        halt_pend_d = 1'b0;
                        state_d     = S_HALTED;
                    end else begin
                        state_d = S_REQ;
                    end
                end else if (halt_i) begin
                    halt_pend_d = 1'b1;
                end
            end

            S_HALTED: begin
                if (redirect_i) begin
                    pc_d        = redirect_tgt;
                    halt_pend_d = 1'b0;
                    state_d     = S_REQ;
                end
            end

            S_ERROR: state_d = S_ERROR;

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            wait_cnt_q   <= '0;
            halt_pend_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_out_q   <= '0;
            inst_pc_q    <= '0;
            fetch_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            wait_cnt_q   <= wait_cnt_d;
            halt_pend_q  <= halt_pend_d;
            inst_valid_q <= inst_valid_d;
            inst_out_q   <= inst_out_d;
            inst_pc_q    <= inst_pc_d;
            fetch_err_q  <= fetch_err_d;
        end
    end

    // Outputs decode straight from flops, so reset drops imem_req without waiting for a clock.
    assign bus.imem_req   = (state_q == S_REQ);
    assign bus.imem_addr  = pc_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.inst_out   = inst_out_q;
    assign bus.inst_pc    = inst_pc_q;
    assign halted_o       = (state_q == S_HALTED);
    assign fetch_err_o    = fetch_err_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: sequential fetch, stall, redirect, halt,
// ack timeout, PC wrap and asynchronous reset, using two instances (RESET_PC 0 and 0xFFFFFFFC).
module tb_fetch_sequencer;
    logic clk;
    logic reset0, reset1;
    logic redirect0, halt0, halted0, ferr0;
    logic [31:0] redirect_pc0;
    logic redirect1, halt1, halted1, ferr1;
    logic [31:0] redirect_pc1;
    int total = 0;
    int bad   = 0;

    fetch_sequencer_if #(.ADDR_W(32)) if0 ();
    fetch_sequencer_if #(.ADDR_W(32)) if1 ();

    fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'h0), .MAX_WAIT(15)) dut0 (
        .clk(clk), .reset(reset0), .bus(if0),
        .redirect_i(redirect0), .redirect_pc_i(redirect_pc0), .halt_i(halt0),
        .halted_o(halted0), .fetch_err_o(ferr0)
    );

    fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .MAX_WAIT(15)) dut1 (
        .clk(clk), .reset(reset1), .bus(if1),
        .redirect_i(redirect1), .redirect_pc_i(redirect_pc1), .halt_i(halt1),
        .halted_o(halted1), .fetch_err_o(ferr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset0 = 1'b0; reset1 = 1'b0;
        redirect0 = 0; redirect_pc0 = '0; halt0 = 0;
        if0.imem_ack = 0; if0.imem_rdata = '0; if0.inst_ready = 0;
        redirect1 = 0; redirect_pc1 = '0; halt1 = 0;
        if1.imem_ack = 0; if1.imem_rdata = '0; if1.inst_ready = 0;
        tick(); tick();
        total++; if ({if0.imem_req, if0.inst_valid, halted0, ferr0} !== 4'b0000) begin bad++; $display("FAIL rst_outputs: got=%b exp=0000", {if0.imem_req, if0.inst_valid, halted0, ferr0}); end
        total++; if (if0.imem_addr !== 32'h0) begin bad++; $display("FAIL rst_pc: got=%h exp=00000000", if0.imem_addr); end
        reset0 = 1'b1;
        tick();
        total++; if ({if0.imem_req, if0.imem_addr} !== {1'b1, 32'h0}) begin bad++; $display("FAIL first_req: got=%b/%h exp=1/00000000", if0.imem_req, if0.imem_addr); end
    endtask

    // Ack one cycle after each request, decode always ready: REQ, REQ, HOLD per instruction.
    task automatic test_sequential();
        for (int k = 0; k < 4; k++) begin
            total++; if ({if0.imem_req, if0.imem_addr} !== {1'b1, 32'(4 * k)}) begin bad++; $display("FAIL seq_req%0d: got=%b/%h exp=1/%h", k, if0.imem_req, if0.imem_addr, 32'(4 * k)); end
            tick();
            if0.imem_ack = 1; if0.imem_rdata = 32'hA000_0000 + 32'(k);
            tick();
            if0.imem_ack = 0;
            total++; if ({if0.inst_valid, if0.imem_req, if0.inst_pc, if0.inst_out} !== {1'b1, 1'b0, 32'(4 * k), 32'hA000_0000 + 32'(k)}) begin bad++; $display("FAIL seq_deliver%0d: got=%b%b/%h/%h exp=10/%h/%h", k, if0.inst_valid, if0.imem_req, if0.inst_pc, if0.inst_out, 32'(4 * k), 32'hA000_0000 + 32'(k)); end
            if0.inst_ready = 1;
            tick();
            if0.inst_ready = 0;
        end
    endtask

    task automatic test_hold_stall();
        tick();
        if0.imem_ack = 1; if0.imem_rdata = 32'hDEAD_BEEF;
        tick();
        if0.imem_ack = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++; if ({if0.inst_valid, if0.imem_req, if0.inst_out, if0.inst_pc} !== {2'b10, 32'hDEAD_BEEF, 32'h10}) begin bad++; $display("FAIL stall%0d: got=%b%b/%h/%h exp=10/deadbeef/00000010", c, if0.inst_valid, if0.imem_req, if0.inst_out, if0.inst_pc); end
        end
        if0.inst_ready = 1;
        tick();
        if0.inst_ready = 0;
        total++; if ({if0.inst_valid, if0.imem_req, if0.imem_addr} !== {2'b01, 32'h14}) begin bad++; $display("FAIL stall_release: got=%b%b/%h exp=01/00000014", if0.inst_valid, if0.imem_req, if0.imem_addr); end
    endtask

    task automatic test_redirect();
        tick();
        if0.imem_ack = 1; if0.imem_rdata = 32'h5555_5555;
        redirect0 = 1; redirect_pc0 = 32'h103;
        tick();
        redirect0 = 0;
        total++; if ({if0.imem_req, if0.inst_valid} !== 2'b00) begin bad++; $display("FAIL redir_drop: got=%b exp=00", {if0.imem_req, if0.inst_valid}); end
        // Ack still high during DROP must be ignored.
        tick();
        if0.imem_ack = 0;
        total++; if ({if0.imem_req, if0.inst_valid, if0.imem_addr} !== {2'b10, 32'h100}) begin bad++; $display("FAIL redir_target: got=%b%b/%h exp=10/00000100", if0.imem_req, if0.inst_valid, if0.imem_addr); end
    endtask

    task automatic test_halt();
        redirect0 = 1; redirect_pc0 = 32'h20;
        tick();
        redirect0 = 0;
        tick();
        total++; if ({if0.imem_req, if0.imem_addr} !== {1'b1, 32'h20}) begin bad++; $display("FAIL halt_setup: got=%b/%h exp=1/00000020", if0.imem_req, if0.imem_addr); end
        halt0 = 1;
        tick();
        halt0 = 0;
        if0.imem_ack = 1; if0.imem_rdata = 32'h2020_2020;
        tick();
        if0.imem_ack = 0;
        total++; if ({if0.inst_valid, halted0, if0.inst_pc, if0.inst_out} !== {2'b10, 32'h20, 32'h2020_2020}) begin bad++; $display("FAIL halt_deliver: got=%b%b/%h/%h exp=10/00000020/20202020", if0.inst_valid, halted0, if0.inst_pc, if0.inst_out); end
        if0.inst_ready = 1;
        tick();
        if0.inst_ready = 0;
        tick();
        total++; if ({halted0, if0.imem_req, if0.inst_valid} !== 3'b100) begin bad++; $display("FAIL halted_state: got=%b exp=100", {halted0, if0.imem_req, if0.inst_valid}); end
        // Redirect and halt together: redirect wins and the pending halt is dropped.
        redirect0 = 1; redirect_pc0 = 32'h40; halt0 = 1;
        tick();
        redirect0 = 0; halt0 = 0;
        total++; if ({halted0, if0.imem_req, if0.imem_addr} !== {2'b01, 32'h40}) begin bad++; $display("FAIL halt_exit: got=%b%b/%h exp=01/00000040", halted0, if0.imem_req, if0.imem_addr); end
        tick();
        if0.imem_ack = 1; if0.imem_rdata = 32'h4040_4040;
        tick();
        if0.imem_ack = 0; if0.inst_ready = 1;
        tick();
        if0.inst_ready = 0;
        total++; if ({halted0, if0.imem_req, if0.imem_addr} !== {2'b01, 32'h44}) begin bad++; $display("FAIL halt_cleared: got=%b%b/%h exp=01/00000044", halted0, if0.imem_req, if0.imem_addr); end
    endtask

    task automatic test_timeout();
        // Ack on the 15th waiting cycle is still accepted.
        for (int c = 0; c < 14; c++) tick();
        if0.imem_ack = 1; if0.imem_rdata = 32'h1515_1515;
        tick();
        if0.imem_ack = 0;
        total++; if ({if0.inst_valid, ferr0, if0.inst_pc} !== {2'b10, 32'h44}) begin bad++; $display("FAIL late_ack: got=%b%b/%h exp=10/00000044", if0.inst_valid, ferr0, if0.inst_pc); end
        if0.inst_ready = 1;
        tick();
        if0.inst_ready = 0;
        for (int c = 0; c < 14; c++) tick();
        total++; if ({ferr0, if0.imem_req} !== 2'b01) begin bad++; $display("FAIL pre_timeout: got=%b exp=01", {ferr0, if0.imem_req}); end
        tick();
        total++; if ({ferr0, if0.imem_req, if0.inst_valid} !== 3'b100) begin bad++; $display("FAIL timeout: got=%b exp=100", {ferr0, if0.imem_req, if0.inst_valid}); end
        if0.imem_ack = 1; if0.inst_ready = 1; redirect0 = 1; redirect_pc0 = 32'h80;
        tick(); tick(); tick();
        if0.imem_ack = 0; if0.inst_ready = 0; redirect0 = 0;
        total++; if ({ferr0, if0.imem_req, if0.inst_valid} !== 3'b100) begin bad++; $display("FAIL error_sticky: got=%b exp=100", {ferr0, if0.imem_req, if0.inst_valid}); end
        #2 reset0 = 1'b0;
        #1;
        total++; if ({ferr0, if0.imem_req} !== 2'b00) begin bad++; $display("FAIL error_reset: got=%b exp=00", {ferr0, if0.imem_req}); end
        tick();
        reset0 = 1'b1;
    endtask

    task automatic test_wrap_async_reset();
        reset1 = 1'b1;
        tick();
        total++; if ({if1.imem_req, if1.imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin bad++; $display("FAIL wrap_first: got=%b/%h exp=1/fffffffc", if1.imem_req, if1.imem_addr); end
        tick();
        if1.imem_ack = 1; if1.imem_rdata = 32'hCAFE_F00D;
        tick();
        if1.imem_ack = 0;
        total++; if ({if1.inst_valid, if1.inst_pc, if1.inst_out} !== {1'b1, 32'hFFFF_FFFC, 32'hCAFE_F00D}) begin bad++; $display("FAIL wrap_deliver: got=%b/%h/%h exp=1/fffffffc/cafef00d", if1.inst_valid, if1.inst_pc, if1.inst_out); end
        if1.inst_ready = 1;
        tick();
        if1.inst_ready = 0;
        total++; if ({if1.imem_req, if1.imem_addr} !== {1'b1, 32'h0}) begin bad++; $display("FAIL wrap_pc: got=%b/%h exp=1/00000000", if1.imem_req, if1.imem_addr); end
        tick();
        #2 reset1 = 1'b0;
        #1;
        total++; if ({if1.imem_req, if1.inst_valid} !== 2'b00) begin bad++; $display("FAIL async_reset: got=%b exp=00", {if1.imem_req, if1.inst_valid}); end
        if1.imem_ack = 1; if1.imem_rdata = 32'h7777_7777;
        tick();
        reset1 = 1'b1;
        tick();
        if1.imem_ack = 0;
        total++; if ({if1.imem_req, if1.inst_valid, if1.imem_addr} !== {2'b10, 32'hFFFF_FFFC}) begin bad++; $display("FAIL post_reset_ack: got=%b%b/%h exp=10/fffffffc", if1.imem_req, if1.inst_valid, if1.imem_addr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_hold_stall();
        test_redirect();
        test_halt();
        test_timeout();
        test_wrap_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
